// File: rtl/seq_pkg.sv
// Shared types for the program sequencer.
//   opcode_e  : 3-bit instruction opcodes returned by the instruction memory
//   state_e   : sequencer FSM states
//   op_sel_e  : serial datapath operation select driven during a burst
//   SYNC_STAGES : depth of the switch input synchroniser
package seq_pkg;

    typedef enum logic [2:0] {
        OP_NOP      = 3'b000,
        OP_STALL    = 3'b001,
        OP_MUL_YD   = 3'b010,
        OP_MUL_X1D  = 3'b011,
        OP_ADD_YX   = 3'b100,
        OP_RSVD     = 3'b101,
        OP_WAIT_OFF = 3'b110,
        OP_WAIT_ON  = 3'b111
    } opcode_e;

    typedef enum logic [2:0] {
        FETCH,
        SERIAL,
        STALL,
        WAIT_ON,
        WAIT_OFF
    } state_e;

    typedef enum logic [1:0] {
        SEL_NONE    = 2'b00,
        SEL_MUL_YD  = 2'b01,
        SEL_MUL_X1D = 2'b10,
        SEL_ADD_YX  = 2'b11
    } op_sel_e;

    localparam int SYNC_STAGES = 2;

    // Map a serial-arithmetic opcode onto the datapath select; anything
    // else selects no operation.
    function automatic op_sel_e op_to_sel(input opcode_e op);
        op_sel_e sel;
        sel = SEL_NONE;
        case (op)
            OP_MUL_YD:  sel = SEL_MUL_YD;
            OP_MUL_X1D: sel = SEL_MUL_X1D;
            OP_ADD_YX:  sel = SEL_ADD_YX;
            default:    sel = SEL_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/seq_ctrl_sw_sync.sv
// Multi-flop synchroniser for the asynchronous switch input.
//   i_clk  : clock, rising edge
//   i_rst  : asynchronous active-high reset, clears every stage to 0
//   i_sw   : raw asynchronous switch
//   o_sw_s : synchronised switch, lags i_sw by STAGES clock edges
module sw_sync
    import seq_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sw,
    output logic o_sw_s
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], i_sw};
        end
    end

    assign o_sw_s = sync_q[STAGES-1];

endmodule

// File: rtl/seq_ctrl.sv
// Program sequencer for the bit-serial datapath.
// Fetches 3-bit opcodes from an 8-entry instruction memory addressed by o_pc,
// times serial MAC/ADD bursts, fixed stalls and switch waits, and issues the
// per-bit strobes consumed by the bit-serial arithmetic unit.
//   i_clk     : clock, rising edge
//   i_rst     : asynchronous active-high reset
//   i_sw      : external switch, asynchronous to i_clk
//   i_instr   : opcode at o_pc (combinational memory read)
//   o_pc      : program counter
//   o_busy    : high whenever the sequencer is not fetching
//   o_op_en   : serial datapath bit enable
//   o_op_sel  : serial operation select, 00 outside a burst
//   o_bit_idx : current serial bit, LSB first
//   o_first   : bit 0 of a burst
//   o_last    : bit WIDTH-1 of a burst
//   o_done    : one-cycle pulse when the program counter wraps to 0
module seq_ctrl
    import seq_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int STALL_CYCLES = 4,
    parameter int PC_W         = 3
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_sw,
    input  logic [2:0]               i_instr,
    output logic [PC_W-1:0]          o_pc,
    output logic                     o_busy,
    output logic                     o_op_en,
    output logic [1:0]               o_op_sel,
    output logic [$clog2(WIDTH)-1:0] o_bit_idx,
    output logic                     o_first,
    output logic                     o_last,
    output logic                     o_done
);

    localparam int BIDX_W  = $clog2(WIDTH);
    localparam int STALL_W = (STALL_CYCLES > 1) ? $clog2(STALL_CYCLES) : 1;

    localparam logic [BIDX_W-1:0]  BIT_LAST   = BIDX_W'(WIDTH - 1);
    localparam logic [STALL_W-1:0] STALL_LOAD = STALL_W'(STALL_CYCLES - 1);
    localparam logic [PC_W-1:0]    PC_LAST    = '1;

    state_e              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [STALL_W-1:0]  stall_q, stall_d;
    logic [BIDX_W-1:0]   bit_q, bit_d;
    op_sel_e             sel_q, sel_d;
    logic                done_q, done_d;
    logic                advance;
    logic                sw_s;

    sw_sync #(
        .STAGES (SYNC_STAGES)
    ) u_sw_sync (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_sw   (i_sw),
        .o_sw_s (sw_s)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= FETCH;
            pc_q    <= '0;
            stall_q <= '0;
            bit_q   <= '0;
            sel_q   <= SEL_NONE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            stall_q <= stall_d;
            bit_q   <= bit_d;
            sel_q   <= sel_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        stall_d = stall_q;
        bit_d   = bit_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        advance = 1'b0;

        case (state_q)
            FETCH: begin
                case (opcode_e'(i_instr))
                    OP_STALL: begin
                        stall_d = STALL_LOAD;
                        state_d = STALL;
                    end
                    OP_MUL_YD, OP_MUL_X1D, OP_ADD_YX: begin
                        sel_d   = op_to_sel(opcode_e'(i_instr));
                        bit_d   = '0;
                        state_d = SERIAL;
                    end
                    OP_WAIT_ON:  state_d = WAIT_ON;
                    OP_WAIT_OFF: state_d = WAIT_OFF;
                    // NOP and the reserved opcode both take a single cycle.
                    default:     advance = 1'b1;
                endcase
            end
            SERIAL: begin
                if (bit_q == BIT_LAST) begin
                    // Clearing select and index here keeps both at zero
                    // for the whole time the datapath is idle.
                    advance = 1'b1;
                    bit_d   = '0;
                    sel_d   = SEL_NONE;
                    state_d = FETCH;
                end else begin
                    bit_d = bit_q + BIDX_W'(1);
                end
            end
            STALL: begin
                if (stall_q == '0) begin
                    advance = 1'b1;
                    state_d = FETCH;
                end else begin
                    stall_d = stall_q - STALL_W'(1);
                end
            end
            WAIT_ON: begin
                if (sw_s) begin
                    advance = 1'b1;
                    state_d = FETCH;
                end
            end
            WAIT_OFF: begin
                if (!sw_s) begin
                    advance = 1'b1;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        // The wrap pulse is registered so it coincides with pc=0 on o_pc.
        if (advance) begin
            pc_d   = pc_q + PC_W'(1);
            done_d = (pc_q == PC_LAST);
        end
    end

    assign o_pc      = pc_q;
    assign o_busy    = (state_q != FETCH);
    assign o_op_en   = (state_q == SERIAL);
    assign o_op_sel  = sel_q;
    assign o_bit_idx = bit_q;
    assign o_first   = o_op_en && (bit_q == '0);
    assign o_last    = o_op_en && (bit_q == BIT_LAST);
    assign o_done    = done_q;

endmodule
